// File: rtl/fsm_transmission.sv
// Transmit-side control FSM for the memory-mapped UART: latches the payload, pulses the
// TX core start, waits for end-of-frame, then clears "send". Optional watchdog: FSM_TX_TIMEOUT_EN.
module fsm_transmission #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              send_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_busy_i,
    input  logic              tx_done_i,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              wr_ctrl_o,
    output logic              send_o,
    output logic              tx_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FREE  = 3'd1,
        ST_START      = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_CLEAR_SEND = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_latch;
    logic              w_timeout;
    logic              r_tx_start;
    logic              r_wr_ctrl;
    logic [DATA_W-1:0] r_tx_data;

`ifdef FSM_TX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tx_err;

    assign w_timeout = (r_state == ST_WAIT_DONE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: zeroed on WAIT_DONE entry, runs only while waiting for end-of-frame
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if ((r_state != ST_WAIT_DONE) && (w_next == ST_WAIT_DONE)) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT_DONE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Sticky error: set by a timeout that lost the race to no done, cleared at the next latch
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tx_err <= 1'b0;
        end else if (w_latch) begin
            r_tx_err <= 1'b0;
        end else if (w_timeout && !tx_done_i) begin
            r_tx_err <= 1'b1;
        end else begin
            r_tx_err <= r_tx_err;
        end
    end

    assign tx_err_o = r_tx_err;
`else
    logic w_unused;

    assign w_unused  = (TIMEOUT_CYCLES != 0);
    assign w_timeout = 1'b0;
    assign tx_err_o  = 1'b0;
`endif

    // Next-state decode; w_latch marks the edge that snapshots the data register
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_i) begin
                    if (!tx_busy_i) begin
                        w_next  = ST_START;
                        w_latch = 1'b1;
                    end else begin
                        w_next = ST_WAIT_FREE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_FREE: begin
                if (!tx_busy_i) begin
                    w_next  = ST_START;
                    w_latch = 1'b1;
                end else begin
                    w_next = ST_WAIT_FREE;
                end
            end
            ST_START: begin
                w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done_i || w_timeout) begin
                    w_next = ST_CLEAR_SEND;
                end else begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_CLEAR_SEND: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state, so pulses are glitch-free
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_wr_ctrl  <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= (w_next == ST_START);
            r_wr_ctrl  <= (w_next == ST_CLEAR_SEND);
            if (w_latch) begin
                r_tx_data <= tx_data_i;
            end else begin
                r_tx_data <= r_tx_data;
            end
        end
    end

    assign tx_start_o = r_tx_start;
    assign wr_ctrl_o  = r_wr_ctrl;
    assign tx_data_o  = r_tx_data;
    assign send_o     = 1'b0;

endmodule

// File: tb/tb_fsm_transmission.sv
// Self-checking bench for fsm_transmission: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the TX control sequence.
module tb_fsm_transmission;

    localparam int DW = 8;
    localparam int TO = 16;
`ifdef FSM_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          send_i;
    logic [DW-1:0] tx_data_i;
    logic          tx_busy_i;
    logic          tx_done_i;
    logic          tx_start_o;
    logic [DW-1:0] tx_data_o;
    logic          wr_ctrl_o;
    logic          send_o;
    logic          tx_err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a frame request is either pending, being started, in flight, or being closed
    bit            m_start   = 1'b0;
    bit            m_wr      = 1'b0;
    bit            m_err     = 1'b0;
    bit            m_flight  = 1'b0;
    bit            m_pending = 1'b0;
    logic [DW-1:0] m_data    = '0;
    int            m_waited  = 0;

    fsm_transmission #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .send_i     (send_i),
        .tx_data_i  (tx_data_i),
        .tx_busy_i  (tx_busy_i),
        .tx_done_i  (tx_done_i),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .wr_ctrl_o  (wr_ctrl_o),
        .send_o     (send_o),
        .tx_err_o   (tx_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit send, input bit busy, input bit done,
                              input logic [DW-1:0] d);
        if (!rst) begin
            m_start = 0; m_wr = 0; m_err = 0; m_flight = 0; m_pending = 0;
            m_data = '0; m_waited = 0;
        end else if (m_wr) begin
            m_wr = 0;
        end else if (m_start) begin
            m_start  = 0;
            m_flight = 1;
            m_waited = 0;
        end else if (m_flight) begin
            m_waited++;
            if (done) begin
                m_flight = 0; m_wr = 1;
            end else if (TO_EN && m_waited == TO) begin
                m_flight = 0; m_wr = 1; m_err = 1;
            end
        end else if (send || m_pending) begin
            if (!busy) begin
                m_start = 1; m_pending = 0; m_data = d; m_err = 0;
            end else begin
                m_pending = 1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit send, input bit busy, input bit done,
                         input logic [DW-1:0] d, input string tag);
        rst_i = rst; send_i = send; tx_busy_i = busy; tx_done_i = done; tx_data_i = d;
        @(posedge clk_i);
        model_edge(rst, send, busy, done, d);
        @(negedge clk_i);
        check_eq({tag, ".tx_start"}, 32'(tx_start_o), 32'(m_start));
        check_eq({tag, ".wr_ctrl"},  32'(wr_ctrl_o),  32'(m_wr));
        check_eq({tag, ".send_o"},   32'(send_o),     32'd0);
        check_eq({tag, ".tx_data"},  32'(tx_data_o),  32'(m_data));
        check_eq({tag, ".tx_err"},   32'(tx_err_o),   32'(m_err));
    endtask

    initial begin
        rst_i = 1'b0; send_i = 1'b0; tx_busy_i = 1'b0; tx_done_i = 1'b0; tx_data_i = '0;
        @(negedge clk_i);

        // Reset held two cycles with send asserted
        cycle(0, 1, 0, 0, 8'hA5, "rst");
        cycle(0, 1, 0, 0, 8'hA5, "rst");

        // Basic frame, payload changes mid-frame, done coincident with START ignored
        cycle(1, 1, 0, 0, 8'hA5, "basic");
        cycle(1, 0, 1, 1, 8'h00, "basic");
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 8'h00, "basic");
        cycle(1, 0, 0, 1, 8'h00, "basic");
        cycle(1, 0, 0, 0, 8'h3C, "basic");
        cycle(1, 0, 0, 1, 8'h3C, "idle_done");
        cycle(1, 0, 0, 0, 8'h3C, "idle_done");

        // Send while TX busy for 10 cycles, then busy falls
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 8'h5A, "busy");
        cycle(1, 0, 0, 0, 8'h77, "busy");
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'h11, "busy");
        cycle(1, 0, 0, 1, 8'h11, "busy");
        cycle(1, 0, 0, 0, 8'h11, "busy");

        // No done: watchdog fires when enabled, then the next send clears the error
        cycle(1, 1, 0, 0, 8'hC3, "timeout");
        for (int i = 0; i < 22; i++) cycle(1, 0, 0, 0, 8'h00, "timeout");
        cycle(1, 1, 0, 0, 8'h96, "timeout");
        cycle(1, 0, 0, 0, 8'h96, "timeout");
        cycle(1, 0, 0, 1, 8'h96, "timeout");
        cycle(1, 0, 0, 0, 8'h96, "timeout");
        cycle(1, 0, 0, 0, 8'h96, "timeout");

        // Reset while waiting for done aborts silently
        cycle(1, 1, 0, 0, 8'hE7, "abort");
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 8'hE7, "abort");
        cycle(0, 0, 1, 1, 8'hE7, "abort");
        cycle(1, 0, 0, 0, 8'hE7, "abort");
        cycle(1, 0, 0, 0, 8'hE7, "abort");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                  DW'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
